dm_ctrl: RTL and testbench

DM_CTRL -- requirements
Module: dm_ctrl

---
 rtl/dm_pkg.sv | 9 +
 rtl/dm_bank.sv | 18 +
 rtl/dm_ctrl.sv | 102 ++++++++++
 tb/tb_dm_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared size encodings, MIPS address-error codes and controller states.
package dm_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_WAIT, ST_RESP} state_t;
endpackage

// File: rtl/dm_bank.sv
// dm_bank: word-organised store with one byte-lane-enabled write port and one asynchronous read port.
module dm_bank #(
  parameter int DEPTH = 4096,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
  assign rdata = mem[raddr];
endmodule

// File: rtl/dm_ctrl.sv
// dm_ctrl: data-memory controller (clear-on-reset, fixed-latency load/store, lane merge, extension).
// Optional address-error exceptions are enabled with DM_ADDR_EXC_EN.
module dm_ctrl
  import dm_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        exc,
  output logic [4:0]  exc_code
);
  localparam int AW = $clog2(DEPTH);
  state_t state_q, state_d;
  logic [AW-1:0] clr_q, idx, bank_waddr;
  logic [3:0] cnt_q, be, bank_be;
  logic we_q, sign_q, fault, leave, commit;
  logic [1:0] size_q;
  logic [31:0] addr_q, wdata_q, pc_q, lane_wd, bank_wd, word, ld;
  logic [15:0] h16;
  logic [7:0] b8;
  assign idx = addr_q[AW+1:2];
  assign leave = state_q == ST_WAIT && cnt_q == 4'(LATENCY);
  assign commit = leave && we_q && !fault;
  assign ready = state_q == ST_IDLE;
  assign resp_valid = state_q == ST_RESP;
  always_comb begin
    be = size_q == SZ_BYTE ? 4'b0001 << addr_q[1:0] :
         size_q == SZ_HALF ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    lane_wd = size_q == SZ_BYTE ? {4{wdata_q[7:0]}} :
              size_q == SZ_HALF ? {2{wdata_q[15:0]}} : wdata_q;
    bank_be = state_q == ST_CLEAR ? 4'hF : commit ? be : 4'h0;
    bank_wd = state_q == ST_CLEAR ? 32'd0 : lane_wd;
    bank_waddr = state_q == ST_CLEAR ? clr_q : idx;
    b8 = 8'(word >> {addr_q[1:0], 3'b000});
    h16 = addr_q[1] ? word[31:16] : word[15:0];
    ld = size_q == SZ_BYTE ? {{24{sign_q & b8[7]}}, b8} :
         size_q == SZ_HALF ? {{16{sign_q & h16[15]}}, h16} : word;
    rdata = resp_valid && !we_q && !fault ? ld : 32'd0;
  end
`ifdef DM_ADDR_EXC_EN
  always_comb begin
    fault = (size_q == SZ_HALF && addr_q[0]) || (size_q[1] && addr_q[1:0] != 2'b00) ||
            addr_q[31:2] >= 30'(DEPTH);
    exc = resp_valid && fault;
    exc_code = exc ? (we_q ? EXC_ADES : EXC_ADEL) : 5'd0;
  end
`else
  assign fault = 1'b0;
  assign exc = 1'b0;
  assign exc_code = 5'd0;
`endif
  always_comb
    state_d = state_q == ST_CLEAR ? (clr_q == AW'(DEPTH - 1) ? ST_IDLE : ST_CLEAR) :
              state_q == ST_IDLE  ? (req ? ST_WAIT : ST_IDLE) :
              state_q == ST_WAIT  ? (leave ? ST_RESP : ST_WAIT) : ST_IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_CLEAR;
      clr_q <= '0;
      cnt_q <= '0;
      we_q <= 1'b0;
      sign_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_CLEAR) clr_q <= clr_q + 1'b1;
      cnt_q <= state_q == ST_WAIT ? cnt_q + 1'b1 : 4'd0;
      if (ready && req) begin
        we_q <= we;
        sign_q <= sign;
        size_q <= size;
        addr_q <= addr;
        wdata_q <= wdata;
        pc_q <= pc;
      end
    end
  dm_bank #(.DEPTH(DEPTH)) u_bank (
    .clk(clk), .be(bank_be), .waddr(bank_waddr), .wdata(bank_wd), .raddr(idx), .rdata(word)
  );
`ifndef SYNTHESIS
  logic [31:0] merged;
  always_comb
    for (int b = 0; b < 4; b++) merged[8*b +: 8] = be[b] ? lane_wd[8*b +: 8] : word[8*b +: 8];
  always_ff @(posedge clk)
    if (commit) $display("@%h: *%h <= %h", pc_q - 32'd4, {addr_q[31:2], 2'b00}, merged);
`endif
endmodule

// File: tb/tb_dm_ctrl.sv
// tb_dm_ctrl: directed self-checking bench for dm_ctrl (DEPTH=16, LATENCY=2).
module tb_dm_ctrl;
  import dm_pkg::*;
  logic clk = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0, sign = 1'b0;
  logic [1:0] size = 2'd0;
  logic [31:0] addr = '0, wdata = '0, pc = 32'h0040_0000;
  logic ready, resp_valid, exc;
  logic [31:0] rdata;
  logic [4:0] exc_code;
  int errors = 0, checks = 0;
  logic [31:0] rd;
  logic ex;
  logic [4:0] ec;
  int lat, n;
  dm_ctrl #(.DEPTH(16), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign(sign),
    .addr(addr), .wdata(wdata), .pc(pc), .ready(ready), .resp_valid(resp_valid),
    .rdata(rdata), .exc(exc), .exc_code(exc_code)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (ready !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (ready !== 1'b1) check("ready_timeout", 32'(ready), 32'd1);
  endtask
  // Inputs are scrambled right after the accepting edge; the DUT must ignore them.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    int c;
    wait_ready(c);
    we = w; size = sz; sign = sg; addr = a; wdata = d; pc = pc + 32'd4; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; size = ~sz; sign = ~sg; addr = 32'hFFFF_FFFC; wdata = $urandom;
  endtask
  task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
    issue(w, sz, sg, a, d);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      check({"rdata_idle"}, rdata, 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    rd = rdata; ex = exc; ec = exc_code;
  endtask
  task automatic ld(input string tag, input logic [1:0] sz, input logic sg,
                    input logic [31:0] a, input logic [31:0] exp);
    access(1'b0, sz, sg, a, 32'd0);
    check(tag, rd, exp);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_exc"}, {27'd0, ec}, 32'd0);
  endtask
  task automatic st(input string tag, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] d);
    access(1'b1, sz, 1'b0, a, d);
    check({tag, "_rdata"}, rd, 32'd0);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_exc"}, 32'(ex), 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_exc", 32'(exc), 32'd0);
    check("rst_exc_code", {27'd0, exc_code}, 32'd0);
    reset = 1'b0;
    wait_ready(n);
    check("clear_cycles", 32'(n), 32'd16);
    ld("lw_0_after_clear", SZ_WORD, 1'b0, 32'h0, 32'h0);
    st("sw_10", SZ_WORD, 32'h10, 32'h8001_FF7F);
    ld("lb_13_signed", SZ_BYTE, 1'b1, 32'h13, 32'hFFFF_FF80);
    ld("lbu_13", SZ_BYTE, 1'b0, 32'h13, 32'h0000_0080);
    check("resp_ready_low", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    check("gap_ready_high", 32'(ready), 32'd1);
    st("sw_10b", SZ_WORD, 32'h10, 32'h1122_3344);
    st("sh_12", SZ_HALF, 32'h12, 32'h0000_BEEF);
    ld("lw_10_merged", SZ_WORD, 1'b0, 32'h10, 32'hBEEF_3344);
    ld("lhu_12", SZ_HALF, 1'b0, 32'h12, 32'h0000_BEEF);
    ld("lh_12_signed", SZ_HALF, 1'b1, 32'h12, 32'hFFFF_BEEF);
    ld("lbu_11", SZ_BYTE, 1'b0, 32'h11, 32'h0000_0033);
    st("sb_11", SZ_BYTE, 32'h11, 32'h0000_005A);
    ld("lw_10_after_sb", SZ_WORD, 1'b0, 32'h10, 32'hBEEF_5A44);
`ifdef DM_ADDR_EXC_EN
    access(1'b1, SZ_WORD, 1'b0, 32'h6, 32'hCAFE_F00D);
    check("sw_6_exc", 32'(ex), 32'd1);
    check("sw_6_code", {27'd0, ec}, 32'd5);
    check("sw_6_lat", 32'(lat), 32'd3);
    ld("lw_4_unchanged", SZ_WORD, 1'b0, 32'h4, 32'h0);
    access(1'b0, SZ_HALF, 1'b1, 32'h3, 32'h0);
    check("lh_3_exc", 32'(ex), 32'd1);
    check("lh_3_code", {27'd0, ec}, 32'd4);
    check("lh_3_rdata", rd, 32'd0);
    access(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h1234_5678);
    check("sw_40_code", {27'd0, ec}, 32'd5);
    ld("lw_0_no_wrap", SZ_WORD, 1'b0, 32'h0, 32'h0);
`else
    st("sw_6_aligned", SZ_WORD, 32'h6, 32'hCAFE_F00D);
    ld("lw_4", SZ_WORD, 1'b0, 32'h4, 32'hCAFE_F00D);
    ld("lh_7_aligned", SZ_HALF, 1'b1, 32'h7, 32'hFFFF_CAFE);
    st("sw_40_wrap", SZ_WORD, 32'h40, 32'h1234_5678);
    ld("lw_0_wrap", SZ_WORD, 1'b0, 32'h0, 32'h1234_5678);
`endif
    issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    check("wait_rst_ready", 32'(ready), 32'd0);
    check("wait_rst_resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_ready(n);
    check("reclear_cycles", 32'(n), 32'd16);
    ld("lw_20_dropped", SZ_WORD, 1'b0, 32'h20, 32'h0);
    ld("lw_10_recleared", SZ_WORD, 1'b0, 32'h10, 32'h0);
    ld("lw_0_recleared", SZ_WORD, 1'b0, 32'h0, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
